decode_hazard_scoreboard: RTL and testbench

//  Read-after-write interlock for the Decode stage and its 16-entry register bank.

---
 rtl/decode_hazard_scoreboard.sv | 164 ++++++++++++++++
 tb/tb_decode_hazard_scoreboard.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_hazard_scoreboard.sv
// Read-after-write interlock for the Decode stage and its 16-entry register bank.
// Each register has a pending-write counter: Decode issuing a writer raises it and
// a bank writeback (port C or port V) lowers it. Decode stalls while a source it
// consumes has writes in flight, or while its destination counter is full.
module decode_hazard_scoreboard #(
  parameter int NREG     = 16,
  parameter int CNT_W    = 2,
  parameter int STALL_TO = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [3:0] Rp,
  input  logic [3:0] Rs,
  input  logic       sel_A,
  input  logic       sel_B,
  input  logic       use_A,
  input  logic       use_B,
  input  logic [3:0] Rg_In,
  input  logic       id_wr,
  input  logic       id_link,
  input  logic       id_wrV,
  input  logic       WE_C,
  input  logic [3:0] Rg_WB,
  input  logic       sel_C,
  input  logic       WE_V,
  input  logic       flush,
  output logic       stall,
  output logic       issue,
  output logic       busy,
  output logic [7:0] stall_cnt,
  output logic       err_underflow,
  output logic       err_timeout
);

  // All-ones is the largest count a register can hold.
  localparam logic [CNT_W-1:0] MAX     = '1;
  localparam logic [7:0]       TO_LAST = 8'(STALL_TO - 1);
  localparam logic [3:0]       R_LINK  = 4'd14;
  localparam logic [3:0]       R_V     = 4'd15;

  logic [CNT_W-1:0] pend     [NREG];
  logic [CNT_W-1:0] pend_nxt [NREG];
  logic [NREG-1:0]  uf_vec;

  logic [3:0] src_a;
  logic [3:0] src_b;
  logic [3:0] dst;
  logic [3:0] wb_c;
  logic       haz_a;
  logic       haz_b;
  logic       haz_d;

  logic [1:0]             inc;
  logic [1:0]             dec;
  logic signed [CNT_W+2:0] net;

  // Signed count after applying this cycle's increments and decrements; a negative
  // value means more writebacks arrived than were outstanding.
  function automatic logic signed [CNT_W+2:0] net_cnt(
    input logic [CNT_W-1:0] cur,
    input logic [1:0]       up,
    input logic [1:0]       down
  );
    return $signed({3'b000, cur})
         + $signed({{(CNT_W+1){1'b0}}, up})
         - $signed({{(CNT_W+1){1'b0}}, down});
  endfunction

  // Clamp a signed net count into the counter range: below zero holds at zero,
  // above MAX holds at MAX.
  function automatic logic [CNT_W-1:0] sat_cnt(input logic signed [CNT_W+2:0] s);
    if (s[CNT_W+2]) begin
      return '0;
    end else if (|s[CNT_W+1:CNT_W]) begin
      return MAX;
    end else begin
      return s[CNT_W-1:0];
    end
  endfunction

  // Resolve effective register addresses and the three hazard sources.
  always_comb begin
    src_a = sel_A   ? R_LINK : Rp;
    src_b = sel_B   ? R_V    : Rs;
    dst   = id_link ? R_LINK : Rg_In;
    wb_c  = sel_C   ? R_LINK : Rg_WB;
    haz_a = use_A && (pend[src_a] != '0);
    haz_b = use_B && (pend[src_b] != '0);
    // A full destination counter cannot absorb another pending write.
    haz_d = (id_wr && (pend[dst] == MAX)) || (id_wrV && (pend[R_V] == MAX));
    stall = id_valid && !flush && (haz_a || haz_b || haz_d);
    issue = id_valid && !flush && !stall;
  end

  // Busy whenever any register still has a write outstanding.
  always_comb begin
    busy = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      busy = busy | (pend[r] != '0);
    end
  end

  // Per-register next count; R15 can move by two when ports C and V both hit it.
  always_comb begin
    inc    = '0;
    dec    = '0;
    net    = '0;
    uf_vec = '0;
    for (int r = 0; r < NREG; r++) begin
      inc = {1'b0, issue && id_wr  && (dst  == 4'(r))}
          + {1'b0, issue && id_wrV && (R_V  == 4'(r))};
      dec = {1'b0, WE_C            && (wb_c == 4'(r))}
          + {1'b0, WE_V            && (R_V  == 4'(r))};
      net         = net_cnt(pend[r], inc, dec);
      uf_vec[r]   = net[CNT_W+2];
      pend_nxt[r] = sat_cnt(net);
    end
  end

  // Pending counters; flush wipes every entry and discards this cycle's updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        pend[r] <= '0;
      end
    end else if (flush) begin
      for (int r = 0; r < NREG; r++) begin
        pend[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREG; r++) begin
        pend[r] <= pend_nxt[r];
      end
    end
  end

  // Consecutive-stall counter, saturating, cleared by any non-stall cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 8'd0;
    end else if (stall) begin
      stall_cnt <= (stall_cnt == 8'hFF) ? 8'hFF : stall_cnt + 8'd1;
    end else begin
      stall_cnt <= 8'd0;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_underflow <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      if (!flush && (|uf_vec)) begin
        err_underflow <= 1'b1;
      end
      if (stall && (stall_cnt == TO_LAST)) begin
        err_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_decode_hazard_scoreboard.sv
// Directed scoreboard bench for decode_hazard_scoreboard: the stimulus process
// queues the hand-computed expected outputs of each cycle, and a monitor on the
// falling edge pops and compares them against the DUT.
module tb_decode_hazard_scoreboard;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [3:0] Rp;
  logic [3:0] Rs;
  logic       sel_A;
  logic       sel_B;
  logic       use_A;
  logic       use_B;
  logic [3:0] Rg_In;
  logic       id_wr;
  logic       id_link;
  logic       id_wrV;
  logic       WE_C;
  logic [3:0] Rg_WB;
  logic       sel_C;
  logic       WE_V;
  logic       flush;
  logic       stall;
  logic       issue;
  logic       busy;
  logic [7:0] stall_cnt;
  logic       err_underflow;
  logic       err_timeout;

  decode_hazard_scoreboard #(
    .NREG(16),
    .CNT_W(2),
    .STALL_TO(64)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .id_valid(id_valid),
    .Rp(Rp),
    .Rs(Rs),
    .sel_A(sel_A),
    .sel_B(sel_B),
    .use_A(use_A),
    .use_B(use_B),
    .Rg_In(Rg_In),
    .id_wr(id_wr),
    .id_link(id_link),
    .id_wrV(id_wrV),
    .WE_C(WE_C),
    .Rg_WB(Rg_WB),
    .sel_C(sel_C),
    .WE_V(WE_V),
    .flush(flush),
    .stall(stall),
    .issue(issue),
    .busy(busy),
    .stall_cnt(stall_cnt),
    .err_underflow(err_underflow),
    .err_timeout(err_timeout)
  );

  typedef struct packed {
    logic [15:0] id;
    logic        stall;
    logic        issue;
    logic        busy;
    logic [7:0]  scnt;
    logic        uf;
    logic        to;
  } exp_t;

  exp_t exp_q[$];
  logic chk_en;
  logic done;
  logic final_chk;
  logic exp_uf;
  logic exp_to;
  int   vec_id;
  int   vectors;
  int   miscompares;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: compare one queued expectation per checked cycle, on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard underrun: got an output cycle with no expected entry");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({stall, issue, busy, stall_cnt, err_underflow, err_timeout} !==
            {e.stall, e.issue, e.busy, e.scnt, e.uf, e.to}) begin
          miscompares++;
          $display("FAIL vec %0d stall/issue/busy/cnt/uf/to: got %b/%b/%b/%0d/%b/%b expected %b/%b/%b/%0d/%b/%b",
                   e.id, stall, issue, busy, stall_cnt, err_underflow, err_timeout,
                   e.stall, e.issue, e.busy, e.scnt, e.uf, e.to);
        end
      end
    end else if (done && !final_chk) begin
      final_chk = 1'b1;
      vectors++;
      if (exp_q.size() != 0) begin
        miscompares++;
        $display("FAIL scoreboard leftover: got %0d unchecked entries expected 0", exp_q.size());
      end
    end
  end

  task automatic idle_in();
    id_valid = 1'b0; Rp = 4'd0; Rs = 4'd0; sel_A = 1'b0; sel_B = 1'b0;
    use_A = 1'b0; use_B = 1'b0; Rg_In = 4'd0; id_wr = 1'b0; id_link = 1'b0;
    id_wrV = 1'b0; WE_C = 1'b0; Rg_WB = 4'd0; sel_C = 1'b0; WE_V = 1'b0;
    flush = 1'b0;
  endtask

  // Queue the expected outputs for the current input set, then advance one clock.
  task automatic cyc(input logic s, input logic i, input logic b, input logic [7:0] c);
    exp_t e;
    e.id    = 16'(vec_id);
    e.stall = s;
    e.issue = i;
    e.busy  = b;
    e.scnt  = c;
    e.uf    = exp_uf;
    e.to    = exp_to;
    exp_q.push_back(e);
    vec_id++;
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    chk_en = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    vec_id      = 0;
    chk_en      = 1'b0;
    done        = 1'b0;
    final_chk   = 1'b0;
    exp_uf      = 1'b0;
    exp_to      = 1'b0;
    rst_n       = 1'b0;
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    // Reset state.
    cyc(0, 0, 0, 8'd0);
    rst_n = 1'b1;
    cyc(0, 0, 0, 8'd0);

    // Writer to R3, then a reader of R3 stalls until the cycle after writeback.
    id_valid = 1; id_wr = 1; Rg_In = 4'd3;
    cyc(0, 1, 0, 8'd0);
    id_wr = 0; use_A = 1; Rp = 4'd3;
    cyc(1, 0, 1, 8'd0);
    WE_C = 1; Rg_WB = 4'd3;
    cyc(1, 0, 1, 8'd1);
    WE_C = 0;
    cyc(0, 1, 0, 8'd2);

    // Reset asserted mid-stall clears state without waiting for a clock edge.
    idle_in(); id_valid = 1; id_wr = 1; Rg_In = 4'd3;
    cyc(0, 1, 0, 8'd0);
    id_wr = 0; use_A = 1; Rp = 4'd3;
    cyc(1, 0, 1, 8'd0);
    rst_n = 1'b0;
    cyc(0, 1, 0, 8'd0);
    rst_n = 1'b1; idle_in();
    cyc(0, 0, 0, 8'd0);

    // Link write to R14; port A redirected to R14; writeback through sel_C.
    id_valid = 1; id_wr = 1; id_link = 1; Rg_In = 4'd0;
    cyc(0, 1, 0, 8'd0);
    idle_in(); id_valid = 1; use_A = 1; sel_A = 1; Rp = 4'd5;
    WE_C = 1; sel_C = 1; Rg_WB = 4'd5;
    cyc(1, 0, 1, 8'd0);
    WE_C = 0; sel_C = 0;
    cyc(0, 1, 0, 8'd1);

    // Three writers fill R7; the fourth waits for one writeback.
    idle_in(); id_valid = 1; id_wr = 1; Rg_In = 4'd7;
    cyc(0, 1, 0, 8'd0);
    cyc(0, 1, 1, 8'd0);
    cyc(0, 1, 1, 8'd0);
    cyc(1, 0, 1, 8'd0);
    WE_C = 1; Rg_WB = 4'd7;
    cyc(1, 0, 1, 8'd1);
    WE_C = 0;
    cyc(0, 1, 1, 8'd2);
    idle_in(); WE_C = 1; Rg_WB = 4'd7;
    cyc(0, 0, 1, 8'd0);
    cyc(0, 0, 1, 8'd0);
    cyc(0, 0, 1, 8'd0);
    idle_in();
    cyc(0, 0, 0, 8'd0);

    // Same-cycle inc and dec on R2 cancel; writeback to idle R9 underflows.
    id_valid = 1; id_wr = 1; Rg_In = 4'd2;
    cyc(0, 1, 0, 8'd0);
    WE_C = 1; Rg_WB = 4'd2;
    cyc(0, 1, 1, 8'd0);
    id_wr = 0; use_A = 1; Rp = 4'd2;
    cyc(1, 0, 1, 8'd0);
    idle_in(); WE_C = 1; Rg_WB = 4'd9;
    cyc(0, 0, 0, 8'd1);
    exp_uf = 1'b1;
    idle_in();
    cyc(0, 0, 0, 8'd0);

    // Flush with pend[4]=2, pend[15]=1 clears everything and ignores that cycle's updates.
    id_valid = 1; id_wr = 1; Rg_In = 4'd4; id_wrV = 1;
    cyc(0, 1, 0, 8'd0);
    id_wrV = 0;
    cyc(0, 1, 1, 8'd0);
    flush = 1; WE_V = 1;
    cyc(0, 0, 1, 8'd0);
    idle_in();
    cyc(0, 0, 0, 8'd0);

    // R15 raised twice, then lowered by two in one cycle via ports C and V.
    id_valid = 1; id_wrV = 1;
    cyc(0, 1, 0, 8'd0);
    cyc(0, 1, 1, 8'd0);
    idle_in(); WE_C = 1; Rg_WB = 4'd15; WE_V = 1;
    cyc(0, 0, 1, 8'd0);
    idle_in();
    cyc(0, 0, 0, 8'd0);

    // Long hazard on R1: timeout after 64 stall cycles, counter saturates at 255.
    id_valid = 1; id_wr = 1; Rg_In = 4'd1;
    cyc(0, 1, 0, 8'd0);
    id_wr = 0; use_A = 1; Rp = 4'd1;
    for (int k = 0; k < 260; k++) begin
      exp_to = (k >= 64);
      cyc(1, 0, 1, (k > 255) ? 8'd255 : 8'(k));
    end
    idle_in();
    cyc(0, 0, 1, 8'd255);
    WE_C = 1; Rg_WB = 4'd1;
    cyc(0, 0, 1, 8'd0);
    idle_in();
    cyc(0, 0, 0, 8'd0);

    done = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
